lemon_fetch: RTL and testbench
==============================

Name: lemon_fetch

Overview:
- Parametrised fetch/PC unit for LemonPC; next generation of the single-cycle PC.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Accepts redirects (branch/jump) from execute, drops stale responses, and buffers one fetched instruction toward decode.
- Detects ebreak and halts fetch.

Parameters:
- XLEN, 64, PC/address width.
- ILEN, 32, instruction width.
- RESET_VEC, 64'h8000_0000, PC value after reset.
- INST_STEP, 4, PC increment per sequential fetch.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_resp_valid  in  1  response valid; memory never stalls responses.
- imem_resp_data  in  ILEN  fetched instruction.
- redirect_valid  in  1  single-cycle redirect pulse.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts.
- out_pc  out  XLEN  PC of out_inst.
- out_inst  out  ILEN  instruction.
- ebreak  out  1  sticky halt flag.

Behaviour:
- Reset (async assert, sync release): pc=RESET_VEC; state=REQ; imem_req_valid=0 during reset; out_valid=0; out_pc=0; out_inst=0; ebreak=0; epoch=0.
- States:
  - REQ: drive imem_req_valid=1, addr=pc. On handshake, latch req_pc=pc and req_epoch=epoch; go to WAIT.
  - WAIT: no request. On imem_resp_valid:
    - Stale (req_epoch≠epoch): drop; go to REQ.
    - Else: load the output buffer with out_pc=req_pc and out_inst=data; set out_valid=1; pc=req_pc+INST_STEP.
    - Then go to HALT if data==32'h0010_0073, otherwise go to FULL.
  - FULL: hold the buffer. On out_valid&&out_ready, clear out_valid and go to REQ. A same-cycle request is not issued; request issue from FULL is a one-cycle bubble by design.
  - HALT: ebreak=1 from the cycle after the ebreak response. The ebreak instruction is still presented to decode. No further requests; redirects are ignored. Exit only by reset.
- Redirect (any state except HALT):
  - pc=redirect_pc and epoch toggles.
  - out_valid clears in the same edge; a buffered instruction is discarded.
  - REQ with a same-cycle handshake: the request is tagged with the old epoch and is dropped later.
  - WAIT: the in-flight response is dropped.
  - FULL: go to REQ.
  - Redirect outranks a same-cycle response and a same-cycle out handshake.
- Arithmetic: PC add wraps modulo 2^XLEN; no alignment check.
- Latency: redirect at edge N gives imem_req_valid with addr=redirect_pc during cycle N+1; for a 1-cycle memory, out_valid rises at edge N+2.
- imem_req_addr is stable while imem_req_valid=1 and ready=0, unless a redirect occurs.
- Reset mid-WAIT: the response is ignored; the state machine restarts at REQ with RESET_VEC.

Optional Feature:
- Macro: LEMON_FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (64-bit, counts accepted out handshakes) and perf_flushed (64-bit, counts dropped or discarded instructions). Both reset to 0 and wrap.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package lemon_pkg holds:
  - state enum FETCH_REQ/WAIT/FULL/HALT;
  - localparam EBREAK_INST=32'h0010_0073;
  - default RESET_VEC.
- One natural sub-module: lemon_fetch_buf, a one-entry valid/ready holding register with flush, instantiated for the output stage.

Test Plan:
- Reset then 1-cycle memory returning addi words -> addrs 0x8000_0000, 0x8000_0004, 0x8000_0008; out_pc matches; ebreak=0.
- out_ready=0 for 5 cycles with a buffered instruction -> out_valid stays 1, out_inst/out_pc stable, no imem_req_valid.
- imem_req_ready low for 3 cycles -> addr held at 0x8000_0004; a single request is counted.
- redirect_valid with redirect_pc=0x8000_0100 while in WAIT -> the in-flight response is dropped; the next request addr is 0x8000_0100.
- Response 32'h0010_0073 at pc 0x8000_000C -> out_inst delivered; ebreak=1 the next cycle; no further requests; a redirect is ignored.
- rst_n pulsed low during WAIT -> outputs return to reset values asynchronously; the fetch restarts at 0x8000_0000. With LEMON_FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/lemon_pkg.sv
// Shared types and constants for the LemonPC fetch unit.
package lemon_pkg;

  // Fetch sequencer states: issue a request, wait for its response,
  // hold a buffered instruction, or stop after an ebreak.
  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_FULL = 2'd2,
    FETCH_HALT = 2'd3
  } fetch_state_e;

  // Encoding of the RV ebreak instruction.
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  // PC value the core starts fetching from after reset.
  localparam logic [63:0] DEFAULT_RESET_VEC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/lemon_fetch_buf.sv
// One-entry valid/ready holding register between fetch and decode.
// A flush drops whatever is held and wins over a load or a consume.
module lemon_fetch_buf
  import lemon_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] loadPc_i,
  input  logic [ILEN-1:0] loadInst_i,
  input  logic            outReady_i,
  output logic            outValid_o,
  output logic [XLEN-1:0] outPc_o,
  output logic [ILEN-1:0] outInst_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] inst_q;

  // Hold one instruction: flush clears, load fills, a downstream accept empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= loadPc_i;
      inst_q  <= loadInst_i;
    end else if (valid_q && outReady_i) begin
      valid_q <= 1'b0;
    end
  end

  assign outValid_o = valid_q;
  assign outPc_o    = pc_q;
  assign outInst_o  = inst_q;

endmodule

// File: rtl/lemon_fetch.sv
// LemonPC fetch/PC unit: owns the PC, keeps a single instruction-memory
// request in flight, tags it with an epoch so responses that were
// overtaken by a redirect are dropped, and buffers one instruction for
// decode. Fetch stops for good (until reset) once an ebreak is fetched.
// Optional build macro LEMON_FETCH_PERF_EN adds perf_fetched/perf_flushed.
module lemon_fetch
  import lemon_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter int              ILEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
  parameter int              INST_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst,
  output logic            ebreak
`ifdef LEMON_FETCH_PERF_EN
  ,
  output logic [63:0]     perf_fetched,
  output logic [63:0]     perf_flushed
`endif
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] reqPc_q;
  logic            epoch_q;
  logic            reqEpoch_q;
  logic            reqValid_q;
  logic            ebreak_q;

  logic            bufValid;
  logic            redirectTake;
  logic            reqFire;
  logic            respStale;
  logic            respTake;
  logic            respIsEbreak;
  logic            outFire;

  // A halted fetch unit ignores redirects entirely.
  assign redirectTake = redirect_valid && (state_q != FETCH_HALT);
  assign reqFire      = reqValid_q && imem_req_ready;
  assign respStale    = (reqEpoch_q != epoch_q);
  assign respTake     = (state_q == FETCH_WAIT) && imem_resp_valid &&
                        !redirect_valid && !respStale;
  assign respIsEbreak = (imem_resp_data == ILEN'(EBREAK_INST));
  assign outFire      = bufValid && out_ready && !redirectTake;

  // Fetch sequencer; the request-valid flag is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_REQ;
      pc_q       <= RESET_VEC;
      reqPc_q    <= RESET_VEC;
      epoch_q    <= 1'b0;
      reqEpoch_q <= 1'b0;
      reqValid_q <= 1'b0;
      ebreak_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH_REQ: begin
          reqValid_q <= 1'b1;
          if (reqFire) begin
            reqPc_q    <= pc_q;
            reqEpoch_q <= epoch_q;
            reqValid_q <= 1'b0;
            state_q    <= FETCH_WAIT;
          end
          if (redirectTake) begin
            pc_q    <= redirect_pc;
            epoch_q <= ~epoch_q;
          end
        end
        FETCH_WAIT: begin
          reqValid_q <= 1'b0;
          if (redirectTake) begin
            pc_q    <= redirect_pc;
            epoch_q <= ~epoch_q;
            if (imem_resp_valid) begin
              state_q    <= FETCH_REQ;
              reqValid_q <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (respStale) begin
              state_q    <= FETCH_REQ;
              reqValid_q <= 1'b1;
            end else begin
              pc_q <= reqPc_q + XLEN'(INST_STEP);
              if (respIsEbreak) begin
                state_q  <= FETCH_HALT;
                ebreak_q <= 1'b1;
              end else begin
                state_q <= FETCH_FULL;
              end
            end
          end
        end
        FETCH_FULL: begin
          reqValid_q <= 1'b0;
          if (redirectTake) begin
            pc_q       <= redirect_pc;
            epoch_q    <= ~epoch_q;
            state_q    <= FETCH_REQ;
            reqValid_q <= 1'b1;
          end else if (outFire) begin
            state_q    <= FETCH_REQ;
            reqValid_q <= 1'b1;
          end
        end
        FETCH_HALT: begin
          reqValid_q <= 1'b0;
        end
        default: begin
          state_q    <= FETCH_REQ;
          reqValid_q <= 1'b0;
        end
      endcase
    end
  end

  lemon_fetch_buf #(
    .XLEN(XLEN),
    .ILEN(ILEN)
  ) u_outBuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirectTake),
    .load_i     (respTake),
    .loadPc_i   (reqPc_q),
    .loadInst_i (imem_resp_data),
    .outReady_i (out_ready),
    .outValid_o (bufValid),
    .outPc_o    (out_pc),
    .outInst_o  (out_inst)
  );

  assign imem_req_valid = reqValid_q;
  assign imem_req_addr  = pc_q;
  assign out_valid      = bufValid;
  assign ebreak         = ebreak_q;

`ifdef LEMON_FETCH_PERF_EN
  logic [63:0] perfFetched_q;
  logic [63:0] perfFlushed_q;
  logic        respDrop;
  logic        bufDiscard;

  // A response is lost when it is stale or overtaken by a redirect in the same cycle.
  assign respDrop   = (state_q == FETCH_WAIT) && imem_resp_valid &&
                      (redirect_valid || respStale);
  assign bufDiscard = redirectTake && bufValid;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfFetched_q <= '0;
      perfFlushed_q <= '0;
    end else begin
      if (outFire) begin
        perfFetched_q <= perfFetched_q + 64'd1;
      end
      if (respDrop || bufDiscard) begin
        perfFlushed_q <= perfFlushed_q + 64'd1;
      end
    end
  end

  assign perf_fetched = perfFetched_q;
  assign perf_flushed = perfFlushed_q;
`endif

endmodule

// File: tb/tb_lemon_fetch.sv
// Directed bench for lemon_fetch: a behavioural instruction memory with
// configurable response delay plus one task per scenario.
module tb_lemon_fetch;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        ebreak;
`ifdef LEMON_FETCH_PERF_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_flushed;
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0] reqLog[$];
  logic [63:0] ebreakAddr = 64'd0;
  int          memDelay   = 0;

  lemon_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .ebreak          (ebreak)
`ifdef LEMON_FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_flushed    (perf_flushed)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: addi x1,x1,addr[13:2] everywhere except the ebreak slot.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    if (a == ebreakAddr) return EBREAK;
    return {a[13:2], 5'd1, 3'b000, 5'd1, 7'h13};
  endfunction

  // Behavioural memory: log each accepted request, answer it 1+memDelay cycles later.
  initial begin
    logic [63:0] a;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        a = imem_req_addr;
        reqLog.push_back(a);
        @(posedge clk);
        repeat (memDelay) @(posedge clk);
        #1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = memWord(a);
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
      end
    end
  end

  // Hold reset for two cycles, then release on a falling edge.
  task automatic applyReset(input logic outReadyVal);
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = outReadyVal;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    reqLog.delete();
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a falling edge where a request handshake is pending.
  task automatic waitReqFire(output logic [63:0] addr, output bit ok);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        addr = imem_req_addr;
        ok   = 1'b1;
        break;
      end
    end
  endtask

  // Wait (bounded) for a falling edge where decode sees a valid instruction.
  task automatic waitOutValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Outputs while reset is held low.
  task automatic test_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_valid got=%b want=0", imem_req_valid); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_pc !== 64'd0) begin bad++; $display("[TB] FAIL reset_out_pc got=%h want=0", out_pc); end
    total++; if (out_inst !== 32'd0) begin bad++; $display("[TB] FAIL reset_out_inst got=%h want=0", out_inst); end
    total++; if (ebreak !== 1'b0) begin bad++; $display("[TB] FAIL reset_ebreak got=%b want=0", ebreak); end
    total++; if (imem_req_addr !== BASE) begin bad++; $display("[TB] FAIL reset_addr got=%h want=%h", imem_req_addr, BASE); end
`ifdef LEMON_FETCH_PERF_EN
    total++; if (perf_fetched !== 64'd0) begin bad++; $display("[TB] FAIL reset_perf_fetched got=%0d want=0", perf_fetched); end
    total++; if (perf_flushed !== 64'd0) begin bad++; $display("[TB] FAIL reset_perf_flushed got=%0d want=0", perf_flushed); end
`endif
  endtask

  // Three sequential fetches; the third is left sitting in the buffer.
  task automatic test_sequential();
    logic [63:0] gotPc[3];
    logic [31:0] gotInst[3];
    logic [63:0] want;
    logic [63:0] r;
    int          cnt = 0;
    applyReset(1'b1);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) begin
        gotPc[cnt]   = out_pc;
        gotInst[cnt] = out_inst;
        cnt++;
        if (cnt == 3) begin
          out_ready = 1'b0;
          break;
        end
      end
    end
    total++; if (cnt != 3) begin bad++; $display("[TB] FAIL seq_count got=%0d want=3", cnt); end
    for (int i = 0; i < 3; i++) begin
      want = BASE + 64'(4 * i);
      r    = (reqLog.size() > i) ? reqLog[i] : '1;
      total++; if (r !== want) begin bad++; $display("[TB] FAIL seq_req_addr%0d got=%h want=%h", i, r, want); end
      if (i < cnt) begin
        total++; if (gotPc[i] !== want) begin bad++; $display("[TB] FAIL seq_out_pc%0d got=%h want=%h", i, gotPc[i], want); end
        total++; if (gotInst[i] !== memWord(want)) begin bad++; $display("[TB] FAIL seq_out_inst%0d got=%h want=%h", i, gotInst[i], memWord(want)); end
      end
    end
    total++; if (ebreak !== 1'b0) begin bad++; $display("[TB] FAIL seq_ebreak got=%b want=0", ebreak); end
  endtask

  // Decode stalls for five cycles; the buffer must hold and no request may issue.
  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid%0d got=%b want=1", i, out_valid); end
      total++; if (out_pc !== BASE + 64'd8) begin bad++; $display("[TB] FAIL hold_pc%0d got=%h want=%h", i, out_pc, BASE + 64'd8); end
      total++; if (out_inst !== memWord(BASE + 64'd8)) begin bad++; $display("[TB] FAIL hold_inst%0d got=%h want=%h", i, out_inst, memWord(BASE + 64'd8)); end
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_req_valid%0d got=%b want=0", i, imem_req_valid); end
    end
    total++; if (reqLog.size() != 3) begin bad++; $display("[TB] FAIL hold_req_count got=%0d want=3", reqLog.size()); end
  endtask

  // Memory back-pressure: the second address must stay put and count once.
  task automatic test_req_stall();
    logic [63:0] a;
    logic [63:0] r;
    bit          ok;
    bit          found = 1'b0;
    applyReset(1'b1);
    waitReqFire(a, ok);
    total++; if (!ok || a !== BASE) begin bad++; $display("[TB] FAIL stall_first_req ok=%0d got=%h want=%h", ok, a, BASE); end
    @(posedge clk);
    #1 imem_req_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL stall_no_request got=0 want=1"); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      total++; if (imem_req_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid%0d got=%b want=1", i, imem_req_valid); end
      total++; if (imem_req_addr !== BASE + 64'd4) begin bad++; $display("[TB] FAIL stall_addr%0d got=%h want=%h", i, imem_req_addr, BASE + 64'd4); end
    end
    @(posedge clk);
    #1 imem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    r = (reqLog.size() > 1) ? reqLog[1] : '1;
    total++; if (reqLog.size() != 2) begin bad++; $display("[TB] FAIL stall_req_count got=%0d want=2", reqLog.size()); end
    total++; if (r !== BASE + 64'd4) begin bad++; $display("[TB] FAIL stall_req_addr got=%h want=%h", r, BASE + 64'd4); end
  endtask

  // Redirect while a slow response is outstanding: the late response is dropped.
  task automatic test_redirect_wait();
    logic [63:0] a;
    logic [63:0] target = BASE + 64'h100;
    bit          ok;
    bit          fired = 1'b0;
    bit          sawStale = 1'b0;
    memDelay = 2;
    waitReqFire(a, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL rdw_no_request got=0 want=1"); end
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    memDelay       = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid && out_pc !== target) sawStale = 1'b1;
      if (imem_req_valid && imem_req_ready) begin
        a     = imem_req_addr;
        fired = 1'b1;
        break;
      end
    end
    total++; if (!fired || a !== target) begin bad++; $display("[TB] FAIL rdw_next_addr fired=%0d got=%h want=%h", fired, a, target); end
    total++; if (sawStale !== 1'b0) begin bad++; $display("[TB] FAIL rdw_stale_delivered got=%0d want=0", sawStale); end
    waitOutValid(ok);
    total++; if (!ok || out_pc !== target) begin bad++; $display("[TB] FAIL rdw_out_pc ok=%0d got=%h want=%h", ok, out_pc, target); end
    total++; if (out_inst !== memWord(target)) begin bad++; $display("[TB] FAIL rdw_out_inst got=%h want=%h", out_inst, memWord(target)); end
  endtask

  // Redirect with an instruction buffered: discard it, refetch with minimum latency.
  task automatic test_redirect_full();
    logic [63:0] target = BASE + 64'h200;
    bit          ok;
    @(posedge clk);
    #1 out_ready = 1'b0;
    waitOutValid(ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL rdf_no_buffer got=0 want=1"); end
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rdf_discard got=%b want=0", out_valid); end
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("[TB] FAIL rdf_req_valid got=%b want=1", imem_req_valid); end
    total++; if (imem_req_addr !== target) begin bad++; $display("[TB] FAIL rdf_req_addr got=%h want=%h", imem_req_addr, target); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rdf_early_valid got=%b want=0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rdf_latency got=%b want=1", out_valid); end
    total++; if (out_pc !== target) begin bad++; $display("[TB] FAIL rdf_out_pc got=%h want=%h", out_pc, target); end
    total++; if (out_inst !== memWord(target)) begin bad++; $display("[TB] FAIL rdf_out_inst got=%h want=%h", out_inst, memWord(target)); end
  endtask

  // Ebreak at the fourth word: delivered, halts fetch, and redirects are ignored.
  task automatic test_ebreak();
    bit found = 1'b0;
    ebreakAddr = BASE + 64'hC;
    applyReset(1'b1);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid && out_pc === BASE + 64'hC) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL ebk_not_delivered got=0 want=1"); end
    total++; if (out_inst !== EBREAK) begin bad++; $display("[TB] FAIL ebk_inst got=%h want=%h", out_inst, EBREAK); end
    total++; if (ebreak !== 1'b1) begin bad++; $display("[TB] FAIL ebk_flag got=%b want=1", ebreak); end
    total++; if (reqLog.size() != 4) begin bad++; $display("[TB] FAIL ebk_req_count got=%0d want=4", reqLog.size()); end
    redirect_valid = 1'b1;
    redirect_pc    = BASE + 64'h300;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL ebk_req_valid%0d got=%b want=0", i, imem_req_valid); end
    end
    total++; if (ebreak !== 1'b1) begin bad++; $display("[TB] FAIL ebk_sticky got=%b want=1", ebreak); end
    total++; if (reqLog.size() != 4) begin bad++; $display("[TB] FAIL ebk_req_after got=%0d want=4", reqLog.size()); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ebk_consumed got=%b want=0", out_valid); end
    total++; if (out_pc !== BASE + 64'hC) begin bad++; $display("[TB] FAIL ebk_pc_kept got=%h want=%h", out_pc, BASE + 64'hC); end
  endtask

  // Asynchronous reset, first out of HALT, then in the middle of a WAIT.
  task automatic test_reset_wait();
    logic [63:0] a;
    bit          ok;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (ebreak !== 1'b0) begin bad++; $display("[TB] FAIL arst_ebreak got=%b want=0", ebreak); end
    total++; if (out_pc !== 64'd0) begin bad++; $display("[TB] FAIL arst_out_pc got=%h want=0", out_pc); end
    total++; if (out_inst !== 32'd0) begin bad++; $display("[TB] FAIL arst_out_inst got=%h want=0", out_inst); end
    ebreakAddr = 64'd0;
    memDelay   = 3;
    repeat (2) @(negedge clk);
    reqLog.delete();
    rst_n = 1'b1;
    waitReqFire(a, ok);
    total++; if (!ok || a !== BASE) begin bad++; $display("[TB] FAIL arst_first_req ok=%0d got=%h want=%h", ok, a, BASE); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_wait_req got=%b want=0", imem_req_valid); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_wait_out got=%b want=0", out_valid); end
    total++; if (imem_req_addr !== BASE) begin bad++; $display("[TB] FAIL arst_wait_addr got=%h want=%h", imem_req_addr, BASE); end
`ifdef LEMON_FETCH_PERF_EN
    total++; if (perf_fetched !== 64'd0) begin bad++; $display("[TB] FAIL arst_perf_fetched got=%0d want=0", perf_fetched); end
    total++; if (perf_flushed !== 64'd0) begin bad++; $display("[TB] FAIL arst_perf_flushed got=%0d want=0", perf_flushed); end
`endif
    memDelay = 0;
    repeat (6) @(negedge clk);
    reqLog.delete();
    rst_n = 1'b1;
    waitReqFire(a, ok);
    total++; if (!ok || a !== BASE) begin bad++; $display("[TB] FAIL arst_restart_req ok=%0d got=%h want=%h", ok, a, BASE); end
    waitOutValid(ok);
    total++; if (!ok || out_pc !== BASE) begin bad++; $display("[TB] FAIL arst_restart_pc ok=%0d got=%h want=%h", ok, out_pc, BASE); end
    total++; if (out_inst !== memWord(BASE)) begin bad++; $display("[TB] FAIL arst_restart_inst got=%h want=%h", out_inst, memWord(BASE)); end
  endtask

  // Scenario sequence; each task leaves the DUT where the next one expects it.
  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_sequential();
    test_hold();
    test_req_stall();
    test_redirect_wait();
    test_redirect_full();
    test_ebreak();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
